// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared types and encodings for the multicycle RV32I controller.
// Contents:
//   ctrl_state_t  : controller FSM state encoding
//   OP_*          : RV32I major opcodes handled by the controller
//   ALU_*         : alu_control encodings seen by the datapath ALU
//   ALUOP_*       : internal ALUOp encodings fed to alu_decoder
//   ADR_/RES_/SRCA_/SRCB_/IMM_* : datapath mux select encodings
//   branch_taken() : Zero qualification for the branch state
// Optional feature macro: CTRL_BNE_EN (adds bne handling to the branch state).
// -----------------------------------------------------------------------------
package control_pkg;

   typedef enum logic [3:0] {
      INIT     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEMADR   = 4'd3,
      MEMREAD  = 4'd4,
      MEMWB    = 4'd5,
      MEMWRITE = 4'd6,
      EXECUTER = 4'd7,
      EXECUTEI = 4'd8,
      ALUWB    = 4'd9,
      JAL      = 4'd10,
      BEQ      = 4'd11,
      HALT     = 4'd12
   } ctrl_state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic       ADR_PC     = 1'b0;
   localparam logic       ADR_RESULT = 1'b1;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REG   = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   // True when DECODE should route a branch opcode to the branch state.
   function automatic logic branch_supported(input logic [2:0] f3);
`ifdef CTRL_BNE_EN
      return (f3 == F3_BEQ) || (f3 == F3_BNE);
`else
      return (f3 == F3_BEQ);
`endif
   endfunction

   // PC update enable for the branch state: beq takes on Zero, bne on ~Zero.
   function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
`ifdef CTRL_BNE_EN
      return (f3 == F3_BNE) ? ~zero : zero;
`else
      return zero;
`endif
   endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Maps the controller's ALUOp plus instruction fields onto the ALU operation.
// Ports:
//   alu_op_i      [1:0] : 00 add, 01 sub, 10 decode from funct fields
//   funct3_i      [2:0] : instruction[14:12]
//   op5_i               : instruction[5] (1 for R-type, 0 for I-type ALU)
//   funct7_5_i          : instruction[30]
//   alu_control_o [2:0] : ALU operation select
// -----------------------------------------------------------------------------
module alu_decoder
   import control_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [2:0] funct3_i,
   input  logic       op5_i,
   input  logic       funct7_5_i,
   output logic [2:0] alu_control_o
);

   // ALU operation select; unsupported funct3 values fall back to add.
   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_ADD: alu_control_o = ALU_ADD;
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               // funct7[5] is an immediate bit for addi, so only R-type may subtract
               3'b000:  alu_control_o = (op5_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control_o = ALU_SLT;
               3'b110:  alu_control_o = ALU_OR;
               3'b111:  alu_control_o = ALU_AND;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default: alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// FSM controller for the multicycle RV32I core (lw, sw, R-type, I-type ALU,
// jal, beq). Outputs are decoded from the state (and IR fields); the only
// Mealy term is PC_write in the branch state, which follows Zero.
// Ports:
//   clk, reset (async, active-low)
//   op_code[6:0], funct3[2:0], funct7[6:0] : instruction register fields
//   Zero                                    : ALU result is zero
//   adr_src, mem_write, IR_write, reg_write, PC_write : datapath enables/selects
//   result_src, alu_src_a, alu_src_b, imm_src [1:0]   : datapath mux selects
//   alu_control[2:0]                                  : ALU operation
//   halted                                            : high in HALT
// Optional feature macro: CTRL_BNE_EN (bne shares the branch state).
// -----------------------------------------------------------------------------
module multicycle_control
   import control_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op_code,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       Zero,
   output logic       adr_src,
   output logic       mem_write,
   output logic       IR_write,
   output logic       reg_write,
   output logic       PC_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic       halted
);

   ctrl_state_t state_q, state_d;
   logic [1:0]  alu_op_s;

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:  state_d = FETCH;
         FETCH: state_d = DECODE;
         DECODE: begin
            case (op_code)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_RTYPE:          state_d = EXECUTER;
               OP_ITYPE:          state_d = EXECUTEI;
               OP_JAL:            state_d = JAL;
               OP_BRANCH: begin
                  if (branch_supported(funct3)) begin
                     state_d = BEQ;
                  end else begin
                     state_d = HALT;
                  end
               end
               default:           state_d = HALT;
            endcase
         end
         MEMADR: begin
            if (op_code == OP_STORE) begin
               state_d = MEMWRITE;
            end else begin
               state_d = MEMREAD;
            end
         end
         MEMREAD:  state_d = MEMWB;
         MEMWB:    state_d = FETCH;
         MEMWRITE: state_d = FETCH;
         EXECUTER: state_d = ALUWB;
         EXECUTEI: state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         JAL:      state_d = ALUWB;
         BEQ:      state_d = FETCH;
         HALT:     state_d = HALT;
         default:  state_d = HALT;
      endcase
   end

   // Output decode; anything not driven in a state stays at its zero default.
   always_comb begin
      adr_src    = ADR_PC;
      mem_write  = 1'b0;
      IR_write   = 1'b0;
      reg_write  = 1'b0;
      PC_write   = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_REG;
      imm_src    = IMM_I;
      alu_op_s   = ALUOP_ADD;
      halted     = 1'b0;
      case (state_q)
         INIT: begin
         end
         FETCH: begin
            IR_write   = 1'b1;
            PC_write   = 1'b1;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
         end
         DECODE: begin
            // Precompute the jump/branch target from OldPC while decoding.
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            if (op_code == OP_JAL) begin
               imm_src = IMM_J;
            end else begin
               imm_src = IMM_B;
            end
         end
         MEMADR: begin
            alu_src_a = SRCA_REG;
            alu_src_b = SRCB_IMM;
            if (op_code == OP_STORE) begin
               imm_src = IMM_S;
            end else begin
               imm_src = IMM_I;
            end
         end
         MEMREAD: begin
            adr_src = ADR_RESULT;
         end
         MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
         end
         MEMWRITE: begin
            adr_src   = ADR_RESULT;
            mem_write = 1'b1;
         end
         EXECUTER: begin
            alu_src_a = SRCA_REG;
            alu_src_b = SRCB_REG;
            alu_op_s  = ALUOP_FUNCT;
         end
         EXECUTEI: begin
            alu_src_a = SRCA_REG;
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_I;
            alu_op_s  = ALUOP_FUNCT;
         end
         ALUWB: begin
            reg_write = 1'b1;
         end
         JAL: begin
            // Link value PC+4 = OldPC+4; PC takes the target held in ALUOut.
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            PC_write  = 1'b1;
         end
         BEQ: begin
            alu_src_a = SRCA_REG;
            alu_src_b = SRCB_REG;
            alu_op_s  = ALUOP_SUB;
            PC_write  = branch_taken(funct3, Zero);
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op_i      (alu_op_s),
      .funct3_i      (funct3),
      .op5_i         (op_code[5]),
      .funct7_5_i    (funct7[5]),
      .alu_control_o (alu_control)
   );

endmodule
